// File: rtl/rc4_key_search_ctrl.sv
// Top-level sequencer for the RC4 brute-force key search: runs init, KSA and
// PRGA for each candidate key and drops a key on its first non-printable byte.
module rc4_key_search_ctrl #(
  parameter int                   KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  output logic                 init_start,
  output logic                 ksa_start,
  output logic                 prga_start,
  input  logic                 init_finish,
  input  logic                 ksa_finish,
  input  logic                 prga_finish,
  output logic                 eng_reset_n,
  input  logic [7:0]           init_addr_s,
  input  logic [7:0]           ksa_addr_s,
  input  logic [7:0]           prga_addr_s,
  input  logic [7:0]           init_data_s,
  input  logic [7:0]           ksa_data_s,
  input  logic [7:0]           prga_data_s,
  input  logic                 init_wren_s,
  input  logic                 ksa_wren_s,
  input  logic                 prga_wren_s,
  output logic [7:0]           address_s,
  output logic [7:0]           data_s,
  output logic                 wren_s,
  input  logic                 prga_wren_d,
  input  logic [7:0]           prga_data_d,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted
);

  typedef enum logic [3:0] {
    IDLE,
    INIT_GO,
    INIT_WAIT,
    KSA_GO,
    KSA_WAIT,
    PRGA_GO,
    PRGA_WAIT,
    ABORT,
    NEXT_KEY,
    FOUND,
    EXHAUSTED
  } state_t;

  state_t state;
  logic   byte_ok;

  // Plaintext is accepted only as lowercase letters or space.
  assign byte_ok = ((prga_data_d >= 8'h61) && (prga_data_d <= 8'h7A)) ||
                   (prga_data_d == 8'h20);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      key   <= '0;
    end else begin
      case (state)
        IDLE:      if (go) state <= INIT_GO;
        INIT_GO:   state <= INIT_WAIT;
        INIT_WAIT: if (init_finish) state <= KSA_GO;
        KSA_GO:    state <= KSA_WAIT;
        KSA_WAIT:  if (ksa_finish) state <= PRGA_GO;
        PRGA_GO:   state <= PRGA_WAIT;
        // A bad byte beats a finish pulse arriving in the same cycle.
        PRGA_WAIT: begin
          if (prga_wren_d && !byte_ok) state <= ABORT;
          else if (prga_finish)        state <= FOUND;
        end
        ABORT:     state <= NEXT_KEY;
        NEXT_KEY: begin
          if (key == KEY_MAX) begin
            state <= EXHAUSTED;
          end else begin
            key   <= key + KEY_WIDTH'(1);
            state <= INIT_GO;
          end
        end
        FOUND:     state <= FOUND;
        EXHAUSTED: state <= EXHAUSTED;
        default:   state <= IDLE;
      endcase
    end
  end

  always_comb begin
    init_start  = 1'b0;
    ksa_start   = 1'b0;
    prga_start  = 1'b0;
    eng_reset_n = 1'b1;
    address_s   = 8'h00;
    data_s      = 8'h00;
    wren_s      = 1'b0;
    busy        = 1'b1;
    found       = 1'b0;
    exhausted   = 1'b0;
    case (state)
      IDLE:      busy = 1'b0;
      INIT_GO: begin
        init_start = 1'b1;
        address_s  = init_addr_s;
        data_s     = init_data_s;
        wren_s     = init_wren_s;
      end
      INIT_WAIT: begin
        address_s = init_addr_s;
        data_s    = init_data_s;
        wren_s    = init_wren_s;
      end
      KSA_GO: begin
        ksa_start = 1'b1;
        address_s = ksa_addr_s;
        data_s    = ksa_data_s;
        wren_s    = ksa_wren_s;
      end
      KSA_WAIT: begin
        address_s = ksa_addr_s;
        data_s    = ksa_data_s;
        wren_s    = ksa_wren_s;
      end
      PRGA_GO: begin
        prga_start = 1'b1;
        address_s  = prga_addr_s;
        data_s     = prga_data_s;
        wren_s     = prga_wren_s;
      end
      PRGA_WAIT: begin
        address_s = prga_addr_s;
        data_s    = prga_data_s;
        wren_s    = prga_wren_s;
      end
      ABORT:     eng_reset_n = 1'b0;
      NEXT_KEY:  busy = 1'b1;
      FOUND: begin
        busy  = 1'b0;
        found = 1'b1;
      end
      EXHAUSTED: begin
        busy      = 1'b0;
        exhausted = 1'b1;
      end
      default:   busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Self-checking bench for rc4_key_search_ctrl: behavioural engines replay
// per-key plaintext tables and a reference model predicts the search outcome.
module tb_rc4_key_search_ctrl;

  localparam int KW     = 24;
  localparam int NKEYS  = 4;
  localparam int MAXLEN = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          go = 1'b0;
  logic          init_start, ksa_start, prga_start;
  logic          init_finish = 1'b0, ksa_finish = 1'b0, prga_finish = 1'b0;
  logic          eng_reset_n;
  logic [7:0]    init_addr_s = 8'h0, ksa_addr_s = 8'h0, prga_addr_s = 8'h0;
  logic [7:0]    init_data_s = 8'h0, ksa_data_s = 8'h0, prga_data_s = 8'h0;
  logic          init_wren_s = 1'b0, ksa_wren_s = 1'b0, prga_wren_s = 1'b0;
  logic [7:0]    address_s, data_s;
  logic          wren_s;
  logic          prga_wren_d = 1'b0;
  logic [7:0]    prga_data_d = 8'h0;
  logic [KW-1:0] key;
  logic          busy, found, exhausted;

  int checks = 0;
  int failures = 0;

  logic [7:0] msg [NKEYS][MAXLEN];
  int         len [NKEYS];

  int   init_starts = 0, ksa_starts = 0, prga_starts = 0, abort_cycles = 0;
  logic bad_flag = 1'b0, fin_flag = 1'b0;
  int   mux_phase = 0;

  rc4_key_search_ctrl #(.KEY_WIDTH(KW), .KEY_MAX(24'd3)) dut (
    .clk(clk), .reset(reset), .go(go),
    .init_start(init_start), .ksa_start(ksa_start), .prga_start(prga_start),
    .init_finish(init_finish), .ksa_finish(ksa_finish), .prga_finish(prga_finish),
    .eng_reset_n(eng_reset_n),
    .init_addr_s(init_addr_s), .ksa_addr_s(ksa_addr_s), .prga_addr_s(prga_addr_s),
    .init_data_s(init_data_s), .ksa_data_s(ksa_data_s), .prga_data_s(prga_data_s),
    .init_wren_s(init_wren_s), .ksa_wren_s(ksa_wren_s), .prga_wren_s(prga_wren_s),
    .address_s(address_s), .data_s(data_s), .wren_s(wren_s),
    .prga_wren_d(prga_wren_d), .prga_data_d(prga_data_d),
    .key(key), .busy(busy), .found(found), .exhausted(exhausted)
  );

  always #5 clk = ~clk;

  function automatic bit printable(input logic [7:0] b);
    return (b == 8'h20) || (b inside {[8'h61:8'h7A]});
  endfunction

  function automatic logic [7:0] rand_valid();
    int r;
    r = $urandom_range(0, 26);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  // Reference: the search ends on the first key whose whole message is printable.
  function automatic int first_good_key();
    for (int k = 0; k < NKEYS; k++) begin
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < len[k]; i++)
        if (!printable(msg[k][i])) ok = 1'b0;
      if (ok) return k;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Engine models: latency counters, random S-RAM traffic, stray pulses while idle.
  initial begin
    int icnt, kcnt, pidx, k;
    bit pon;
    icnt = 0; kcnt = 0; pidx = 0; pon = 1'b0;
    forever begin
      @(negedge clk);
      init_finish = 1'b0; ksa_finish = 1'b0; prga_finish = 1'b0;
      prga_wren_d = 1'b0; prga_data_d = 8'h00;
      bad_flag = 1'b0; fin_flag = 1'b0;
      init_addr_s = {4'h1, 4'($urandom)}; init_data_s = {4'h9, 4'($urandom)};
      ksa_addr_s  = {4'h2, 4'($urandom)}; ksa_data_s  = {4'hA, 4'($urandom)};
      prga_addr_s = {4'h3, 4'($urandom)}; prga_data_s = {4'hB, 4'($urandom)};
      init_wren_s = 1'($urandom); ksa_wren_s = 1'($urandom); prga_wren_s = 1'($urandom);
      if (!reset || !eng_reset_n) begin
        icnt = 0; kcnt = 0; pon = 1'b0;
      end else begin
        if (icnt > 0) begin
          icnt--;
          if (icnt == 0) init_finish = 1'b1;
        end else if (!init_start && $urandom_range(0, 7) == 0) init_finish = 1'b1;
        if (init_start) icnt = $urandom_range(1, 4);
        if (kcnt > 0) begin
          kcnt--;
          if (kcnt == 0) ksa_finish = 1'b1;
        end else if (!ksa_start && $urandom_range(0, 7) == 0) ksa_finish = 1'b1;
        if (ksa_start) kcnt = $urandom_range(1, 4);
        if (prga_start) begin
          pon = 1'b1; pidx = 0;
        end else if (pon) begin
          if ($urandom_range(0, 3) != 0) begin
            k = int'(key);
            prga_wren_d = 1'b1;
            prga_data_d = msg[k][pidx];
            bad_flag = !printable(prga_data_d);
            pidx++;
            if (pidx == len[k]) begin
              prga_finish = 1'b1; fin_flag = 1'b1; pon = 1'b0;
            end
          end
        end else begin
          prga_wren_d = 1'($urandom);
          prga_data_d = 8'h00;
          if ($urandom_range(0, 7) == 0) prga_finish = 1'b1;
        end
      end
    end
  end

  // Mux monitor: the engine whose start was seen last owns S-RAM until abort or idle.
  initial begin
    logic [16:0] want;
    forever begin
      tick();
      if (init_start)       mux_phase = 1;
      else if (ksa_start)   mux_phase = 2;
      else if (prga_start)  mux_phase = 3;
      else if (!eng_reset_n) mux_phase = 0;
      if (!busy) mux_phase = 0;
      case (mux_phase)
        1:       want = {init_addr_s, init_data_s, init_wren_s};
        2:       want = {ksa_addr_s, ksa_data_s, ksa_wren_s};
        3:       want = {prga_addr_s, prga_data_s, prga_wren_s};
        default: want = 17'h0;
      endcase
      checkOutput("mux", 32'({address_s, data_s, wren_s}), 32'(want));
      if (init_start) init_starts++;
      if (ksa_start) ksa_starts++;
      if (prga_start) prga_starts++;
      if (!eng_reset_n) abort_cycles++;
    end
  end

  task automatic applyReset();
    reset = 1'b0;
    go = 1'b0;
    tick();
    init_starts = 0; ksa_starts = 0; prga_starts = 0; abort_cycles = 0;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_found_exh", 32'({found, exhausted}), 32'd0);
    checkOutput("rst_key", 32'(key), 32'd0);
    checkOutput("rst_starts", 32'({init_start, ksa_start, prga_start}), 32'd0);
    checkOutput("rst_eng_reset_n", 32'(eng_reset_n), 32'd1);
    checkOutput("rst_mux", 32'({address_s, data_s, wren_s}), 32'd0);
    reset = 1'b1;
    tick();
    tick();
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_wren", 32'(wren_s), 32'd0);
  endtask

  // Invalid byte at edge m: ABORT in m+1, NEXT_KEY in m+2, INIT_GO with key+1 in m+3.
  task automatic abortTiming(input int k);
    int n;
    n = 0;
    while (!bad_flag && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("abort_bad_seen", 32'(bad_flag), 32'd1);
    tick();
    checkOutput("abort_eng_reset_low", 32'(eng_reset_n), 32'd0);
    checkOutput("abort_not_found", 32'(found), 32'd0);
    checkOutput("abort_key_held", 32'(key), 32'(k));
    tick();
    checkOutput("nextkey_eng_reset_high", 32'(eng_reset_n), 32'd1);
    checkOutput("nextkey_busy_nostart", 32'({busy, init_start}), 32'b10);
    tick();
    checkOutput("nextkey_init_start", 32'(init_start), 32'd1);
    checkOutput("nextkey_key_inc", 32'(key), 32'(k + 1));
  endtask

  task automatic applyStimulus(input string name, input bit do_abort);
    int fk, tried, n;
    bit last_fin;
    fk = first_good_key();
    tried = (fk < 0) ? NKEYS : fk + 1;
    applyReset();
    go = 1'b1;
    tick();
    checkOutput({name, ":go_to_init_start"}, 32'(init_start), 32'd1);
    go = 1'b0;
    if (do_abort) abortTiming(0);
    n = 0;
    last_fin = 1'b0;
    while (!(found || exhausted) && n < 3000) begin
      last_fin = fin_flag;
      tick();
      n++;
    end
    checkOutput({name, ":done"}, 32'(found || exhausted), 32'd1);
    if (fk >= 0) checkOutput({name, ":found_latency"}, 32'(last_fin), 32'd1);
    checkOutput({name, ":found"}, 32'(found), 32'(fk >= 0));
    checkOutput({name, ":exhausted"}, 32'(exhausted), 32'(fk < 0));
    checkOutput({name, ":key"}, 32'(key), 32'((fk < 0) ? NKEYS - 1 : fk));
    checkOutput({name, ":busy"}, 32'(busy), 32'd0);
    checkOutput({name, ":init_starts"}, 32'(init_starts), 32'(tried));
    checkOutput({name, ":ksa_starts"}, 32'(ksa_starts), 32'(tried));
    checkOutput({name, ":prga_starts"}, 32'(prga_starts), 32'(tried));
    checkOutput({name, ":abort_cycles"}, 32'(abort_cycles), 32'(tried - ((fk >= 0) ? 1 : 0)));
    go = 1'b1;
    repeat (3) tick();
    checkOutput({name, ":terminal_hold"}, 32'({found, exhausted, busy}), 32'({fk >= 0, fk < 0, 1'b0}));
    checkOutput({name, ":no_restart"}, 32'(init_starts), 32'(tried));
    go = 1'b0;
  endtask

  task automatic fillValid(input int k, input int n);
    len[k] = n;
    for (int i = 0; i < n; i++) msg[k][i] = rand_valid();
  endtask

  initial begin
    int pos;

    // All bytes 'a': key 0 succeeds on its first pass.
    for (int k = 0; k < NKEYS; k++) begin
      len[k] = MAXLEN;
      for (int i = 0; i < MAXLEN; i++) msg[k][i] = 8'h61;
    end
    applyStimulus("all_a", 1'b0);

    // Key 0 has 'A' as third byte, key 1 is printable.
    for (int k = 0; k < NKEYS; k++) fillValid(k, MAXLEN);
    msg[0][2] = 8'h41;
    applyStimulus("third_byte_bad", 1'b1);

    // Every key opens with 0x00: key space is exhausted.
    for (int k = 0; k < NKEYS; k++) begin
      fillValid(k, 8);
      msg[k][0] = 8'h00;
    end
    applyStimulus("exhaust", 1'b1);

    // Bad byte is the last one, coinciding with prga_finish.
    for (int k = 0; k < NKEYS; k++) fillValid(k, 16);
    msg[0][15] = 8'h80;
    applyStimulus("bad_with_finish", 1'b1);

    // Range edges: 0x60 and 0x7B rejected, 0x20 and 0x7A accepted.
    for (int k = 0; k < NKEYS; k++) fillValid(k, 20);
    pos = $urandom_range(0, 19);
    msg[0][pos] = 8'h60;
    pos = $urandom_range(0, 19);
    msg[1][pos] = 8'h7B;
    msg[2][0] = 8'h20;
    msg[2][19] = 8'h7A;
    applyStimulus("range_edges", 1'b1);

    // Random messages with occasional arbitrary bytes.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NKEYS; k++) begin
        len[k] = $urandom_range(1, MAXLEN);
        for (int i = 0; i < len[k]; i++)
          msg[k][i] = ($urandom_range(0, 19) == 0) ? 8'($urandom) : rand_valid();
      end
      applyStimulus($sformatf("random%0d", r), 1'b0);
    end

    // Asynchronous reset while key 1 is in KSA.
    for (int k = 0; k < NKEYS; k++) fillValid(k, MAXLEN);
    msg[0][0] = 8'h00;
    applyReset();
    go = 1'b1;
    tick();
    go = 1'b0;
    pos = 0;
    while (!(ksa_start && key == 24'd1) && pos < 2000) begin
      tick();
      pos++;
    end
    checkOutput("midksa_reached", 32'({ksa_start, key}), 32'({1'b1, 24'd1}));
    tick();
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midksa_rst_status", 32'({busy, found, exhausted}), 32'd0);
    checkOutput("midksa_rst_key", 32'(key), 32'd0);
    checkOutput("midksa_rst_mux", 32'({address_s, data_s, wren_s}), 32'd0);
    checkOutput("midksa_rst_ctrl", 32'({init_start, ksa_start, prga_start, eng_reset_n}), 32'b0001);
    tick();
    reset = 1'b1;
    tick();
    tick();
    checkOutput("midksa_stays_idle", 32'({busy, init_start}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
